// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption pipeline stages (Caesar, zigzag,
// scytale): the end-of-ciphertext token, character/key widths and the
// common three-state engine FSM encoding.
package decryption_pkg;

    localparam int D_WIDTH   = 8;
    localparam int KEY_WIDTH = 8;

    localparam logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

    typedef enum logic [1:0] {
        IDLE,
        DECRYPT,
        DISCARD
    } dec_state_e;

endpackage

// File: rtl/scytale_char_buffer.sv
// Character buffer for the scytale engine.
// Synchronous write, combinational read, no reset on the data array.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (0 for addresses beyond the array depth)
module scytale_char_buffer #(
    parameter  int D_WIDTH       = 8,
    parameter  int MAX_NOF_CHARS = 50,
    localparam int IDX_W         = $clog2(MAX_NOF_CHARS)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem [MAX_NOF_CHARS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Index space is a power of two, the array may not be.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < MAX_NOF_CHARS) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/scytale_decryption.sv
// Scytale-cipher decryption engine.
// Buffers ciphertext bytes until the start token, then replays the buffer
// in transposed order (row j, column i -> buf[i*N + j]), one byte per cycle.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   data_i     - ciphertext byte, qualified by valid_i
//   key_N      - row count (scytale_key[15:8])
//   key_M      - column count (scytale_key[7:0])
//   data_o     - plaintext byte, qualified by valid_o (0 when not valid)
//   busy       - high while decrypting/discarding; input is ignored
module scytale_decryption #(
    parameter int D_WIDTH       = decryption_pkg::D_WIDTH,
    parameter int KEY_WIDTH     = decryption_pkg::KEY_WIDTH,
    parameter int MAX_NOF_CHARS = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN =
        decryption_pkg::START_DECRYPTION_TOKEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);

    import decryption_pkg::*;

    localparam int IDX_W = $clog2(MAX_NOF_CHARS);
    localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int PW    = 2 * KEY_WIDTH;

    dec_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [IDX_W-1:0]   raddr_q, raddr_d;
    logic [IDX_W-1:0]   key_n_q, key_n_d;
    logic [IDX_W-1:0]   key_m_q, key_m_d;
    logic               drain_q, drain_d;
    logic [D_WIDTH-1:0] data_o_q, data_o_d;
    logic               valid_o_q, valid_o_d;

    logic               tok_in;
    logic               key_ok;
    logic               wr_en;
    logic [PW-1:0]      prod;
    logic [D_WIDTH-1:0] rdata;
    logic               last_col;
    logic               last_row;

    assign tok_in = (state_q == IDLE) && valid_i && (data_i == START_DECRYPTION_TOKEN);
    assign wr_en  = (state_q == IDLE) && valid_i && (data_i != START_DECRYPTION_TOKEN)
                    && (cnt_q < CNT_W'(MAX_NOF_CHARS));

    // Only used for key validation; addressing stays multiplier-free.
    assign prod   = PW'(key_N) * PW'(key_M);
    assign key_ok = (key_N != '0) && (key_M != '0) && (prod == PW'(cnt_q));

    assign last_col = (i_q == key_m_q - IDX_W'(1));
    assign last_row = (j_q == key_n_q - IDX_W'(1));

    scytale_char_buffer #(
        .D_WIDTH       (D_WIDTH),
        .MAX_NOF_CHARS (MAX_NOF_CHARS)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (IDX_W'(cnt_q)),
        .wdata (data_i),
        .raddr (raddr_q),
        .rdata (rdata)
    );

    // State register (plus all datapath flops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            raddr_q   <= '0;
            key_n_q   <= '0;
            key_m_q   <= '0;
            drain_q   <= 1'b0;
            data_o_q  <= '0;
            valid_o_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            j_q       <= j_d;
            raddr_q   <= raddr_d;
            key_n_q   <= key_n_d;
            key_m_q   <= key_m_d;
            drain_q   <= drain_d;
            data_o_q  <= data_o_d;
            valid_o_q <= valid_o_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tok_in) state_d = key_ok ? DECRYPT : DISCARD;
            DECRYPT: if (drain_q) state_d = IDLE;
            DISCARD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        cnt_d     = cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        raddr_d   = raddr_q;
        key_n_d   = key_n_q;
        key_m_d   = key_m_q;
        drain_d   = drain_q;
        data_o_d  = '0;
        valid_o_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (tok_in) begin
                    key_n_d = IDX_W'(key_N);
                    key_m_d = IDX_W'(key_M);
                end
            end
            DECRYPT: begin
                // One extra drain cycle after the last read keeps busy high
                // while the final byte sits on data_o.
                if (!drain_q) begin
                    valid_o_d = 1'b1;
                    data_o_d  = rdata;
                    if (last_col) begin
                        i_d     = '0;
                        j_d     = j_q + IDX_W'(1);
                        raddr_d = j_q + IDX_W'(1);
                        if (last_row) begin
                            drain_d = 1'b1;
                        end
                    end else begin
                        i_d     = i_q + IDX_W'(1);
                        raddr_d = raddr_q + key_n_q;
                    end
                end else begin
                    drain_d = 1'b0;
                    cnt_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    raddr_d = '0;
                end
            end
            DISCARD: begin
                cnt_d   = '0;
                i_d     = '0;
                j_d     = '0;
                raddr_d = '0;
            end
            default: ;
        endcase
    end

    assign data_o  = data_o_q;
    assign valid_o = valid_o_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_scytale_decryption.sv
module tb_scytale_decryption;

    localparam logic [7:0] TOK = 8'hFA;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N;
    logic [7:0] key_M;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] cin_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        int          n;
        int          m;
        int          len;
        logic [63:0] cipher;
        logic [63:0] plain;
        bit          disc;
    } vec_t;

    vec_t tbl[9];

    scytale_decryption #(
        .D_WIDTH       (8),
        .KEY_WIDTH     (8),
        .MAX_NOF_CHARS (50)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key_N   (key_N),
        .key_M   (key_M),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sends cin_q then the token; checks exact cycle-by-cycle output timing.
    task automatic run(input int n, input int m, input bit disc,
                       input bit key_chg, input bit junk, input string nm);
        key_N = 8'(n);
        key_M = 8'(m);
        foreach (cin_q[k]) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = cin_q[k];
        end
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = TOK;
        @(negedge clk);
        valid_i = 1'b0;
        chk({nm, " busy_on_token"}, 32'(busy), 32'd1);
        chk({nm, " no_valid_on_token"}, 32'(valid_o), 32'd0);
        if (key_chg) begin
            key_N = 8'd3;
            key_M = 8'd3;
        end
        if (disc) begin
            @(negedge clk);
            chk({nm, " discard_busy_low"}, 32'(busy), 32'd0);
            chk({nm, " discard_no_valid"}, 32'(valid_o), 32'd0);
            return;
        end
        if (junk) begin
            valid_i = 1'b1;
            data_i  = 8'h33;
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            chk($sformatf("%s valid[%0d]", nm, k), 32'(valid_o), 32'd1);
            chk($sformatf("%s data[%0d]", nm, k), 32'(data_o), 32'(exp_q[k]));
            chk($sformatf("%s busy[%0d]", nm, k), 32'(busy), 32'd1);
            if (junk) data_i = (k == 0) ? TOK : 8'(8'h40 + k);
        end
        @(negedge clk);
        valid_i = 1'b0;
        chk({nm, " end_valid_low"}, 32'(valid_o), 32'd0);
        chk({nm, " end_busy_low"}, 32'(busy), 32'd0);
        chk({nm, " end_data_zero"}, 32'(data_o), 32'd0);
    endtask

    task automatic load_row(input int r);
        cin_q.delete();
        exp_q.delete();
        for (int k = 0; k < tbl[r].len; k++) begin
            cin_q.push_back(tbl[r].cipher[(tbl[r].len - 1 - k) * 8 +: 8]);
            if (!tbl[r].disc) exp_q.push_back(tbl[r].plain[(tbl[r].len - 1 - k) * 8 +: 8]);
        end
    endtask

    initial begin
        // n, m, len, ciphertext, plaintext, discard
        tbl[0] = '{2, 3, 6, "ADBECF", "ABCDEF", 1'b0};
        tbl[1] = '{2, 2, 5, "ABCDE",  "",       1'b1};
        tbl[2] = '{2, 2, 4, "HLEO",   "HELO",   1'b0};
        tbl[3] = '{1, 4, 4, "WXYZ",   "WXYZ",   1'b0};
        tbl[4] = '{0, 4, 4, "WXYZ",   "",       1'b1};
        tbl[5] = '{3, 2, 6, "ADBECF", "AEDCBF", 1'b0};
        tbl[6] = '{2, 3, 0, "",       "",       1'b1};
        tbl[7] = '{4, 1, 4, "WXYZ",   "WXYZ",   1'b0};
        tbl[8] = '{4, 0, 4, "WXYZ",   "",       1'b1};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        key_N   = '0;
        key_M   = '0;
        #3;
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset data_o", 32'(data_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 9; r++) begin
            load_row(r);
            run(tbl[r].n, tbl[r].m, tbl[r].disc, 1'b0, 1'b0, $sformatf("row%0d", r));
        end

        // Key change right after the token must not affect the running message.
        load_row(0);
        run(2, 3, 1'b0, 1'b1, 1'b0, "key_latch");

        // Bytes and a token during DECRYPT are ignored; the next message is clean.
        load_row(0);
        run(2, 3, 1'b0, 1'b0, 1'b1, "busy_ignore");
        load_row(2);
        run(2, 2, 1'b0, 1'b0, 1'b0, "after_ignore");

        // Overflow: 60 bytes, only the first 50 stored.
        cin_q.delete();
        exp_q.delete();
        for (int k = 0; k < 60; k++) cin_q.push_back(8'(k + 1));
        for (int j = 0; j < 5; j++)
            for (int i = 0; i < 10; i++) exp_q.push_back(8'(i * 5 + j + 1));
        run(5, 10, 1'b0, 1'b0, 1'b0, "overflow");

        // Asynchronous reset while the third plaintext byte is on the output.
        key_N = 8'd2;
        key_M = 8'd3;
        load_row(0);
        foreach (cin_q[k]) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = cin_q[k];
        end
        @(negedge clk);
        data_i = TOK;
        @(negedge clk);
        valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_pre data[%0d]", k), 32'(data_o), 32'(exp_q[k]));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst valid_o", 32'(valid_o), 32'd0);
        chk("async_rst busy", 32'(busy), 32'd0);
        chk("async_rst data_o", 32'(data_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("held_rst valid_o", 32'(valid_o), 32'd0);
        rst_n = 1'b1;
        run(2, 3, 1'b0, 1'b0, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
